// File: rtl/aq_axi_sdma_wr_engine.sv
// aq_axi_sdma_wr_engine
//
// Stream-to-memory DMA write engine. Drains a first-word-fall-through FIFO into
// memory over an AXI4 write master (AW/W/B). A transfer of LEN beats starting at
// ADRS is split into INCR bursts of at most MAX_BURST beats that never cross a
// 4 KB boundary. Only one burst is outstanding at a time.
//
// Optional feature: define AQ_SDMA_FRAME_SYNC_EN to hold each transfer in a SYNC
// state after START until FRAME_SYNC is sampled high. Without the macro the
// FRAME_SYNC input is unused and START goes directly to the address phase.
//
// Ports:
//   ACLK, RST           clock, asynchronous active-high reset
//   START, ADRS, LEN    transfer request (accepted only while READY=1)
//   FRAME_SYNC          frame-sync qualifier (only with AQ_SDMA_FRAME_SYNC_EN)
//   READY, DONE, ERR    idle flag, one-cycle completion pulse, sticky bus error
//   FIFO_RE/EMPTY/DATA  FWFT FIFO pop, empty flag, head word
//   M_AXI_*             AXI4 write address, write data and write response
module aq_axi_sdma_wr_engine #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned LEN_W     = 32,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                ACLK,
   input  logic                RST,
   input  logic                START,
   input  logic [ADDR_W-1:0]   ADRS,
   input  logic [LEN_W-1:0]    LEN,
   input  logic                FRAME_SYNC,
   output logic                READY,
   output logic                DONE,
   output logic                ERR,
   output logic                FIFO_RE,
   input  logic                FIFO_EMPTY,
   input  logic [DATA_W-1:0]   FIFO_DATA,
   output logic [ADDR_W-1:0]   M_AXI_AWADDR,
   output logic [7:0]          M_AXI_AWLEN,
   output logic [2:0]          M_AXI_AWSIZE,
   output logic [1:0]          M_AXI_AWBURST,
   output logic [3:0]          M_AXI_AWCACHE,
   output logic [2:0]          M_AXI_AWPROT,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WLAST,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned SZ    = $clog2(BYTES);

   typedef enum logic [2:0] {
      StIdle,
`ifdef AQ_SDMA_FRAME_SYNC_EN
      StSync,
`endif
      StAddr,
      StData,
      StResp
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [8:0]          beats_q, beats_d;
   logic [8:0]          cnt_q, cnt_d;
   logic                awvalid_q, awvalid_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [7:0]          awlen_q, awlen_d;
   logic                wlast_q, wlast_d;
   logic                bready_q, bready_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [ADDR_W-1:0]   start_addr;
   logic [ADDR_W-1:0]   calc_addr;
   logic [LEN_W-1:0]    calc_rem;
   logic [12:0]         page_left;
   logic [8:0]          nb;
   logic                load_aw;
   logic                w_hs;

`ifndef AQ_SDMA_FRAME_SYNC_EN
   logic unused_frame_sync;
   assign unused_frame_sync = FRAME_SYNC;
`endif

   assign start_addr = ADRS & ~ADDR_W'(BYTES - 1);

   // In IDLE the first burst is sized from the request inputs so AWVALID can
   // rise the cycle after START; afterwards the running address/count are used.
   assign calc_addr = (state_q == StIdle) ? start_addr : addr_q;
   assign calc_rem  = (state_q == StIdle) ? LEN : rem_q;

   // Beats left before the next 4 KB page boundary (1 .. 4096/BYTES).
   assign page_left = (13'd4096 - {1'b0, calc_addr[11:0]}) >> SZ;

   always_comb begin
      nb = 9'(MAX_BURST);
      if (calc_rem < LEN_W'(MAX_BURST)) begin
         nb = calc_rem[8:0];
      end
      if (page_left < 13'(nb)) begin
         nb = page_left[8:0];
      end
   end

   assign w_hs = M_AXI_WVALID & M_AXI_WREADY;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      beats_d   = beats_q;
      cnt_d     = cnt_q;
      awvalid_d = awvalid_q;
      awaddr_d  = awaddr_q;
      awlen_d   = awlen_q;
      wlast_d   = wlast_q;
      bready_d  = bready_q;
      done_d    = 1'b0;
      err_d     = err_q;
      load_aw   = 1'b0;

      case (state_q)
         StIdle: begin
            if (START) begin
               addr_d = start_addr;
               rem_d  = LEN;
               err_d  = 1'b0;
               if (LEN == '0) begin
                  done_d = 1'b1;
               end else begin
`ifdef AQ_SDMA_FRAME_SYNC_EN
                  state_d = StSync;
`else
                  load_aw = 1'b1;
`endif
               end
            end
         end
`ifdef AQ_SDMA_FRAME_SYNC_EN
         StSync: begin
            if (FRAME_SYNC) begin
               load_aw = 1'b1;
            end
         end
`endif
         StAddr: begin
            if (M_AXI_AWREADY) begin
               awvalid_d = 1'b0;
               cnt_d     = beats_q;
               wlast_d   = (beats_q == 9'd1);
               state_d   = StData;
            end
         end
         StData: begin
            if (w_hs) begin
               if (wlast_q) begin
                  wlast_d  = 1'b0;
                  bready_d = 1'b1;
                  addr_d   = addr_q + (ADDR_W'(beats_q) << SZ);
                  rem_d    = rem_q - LEN_W'(beats_q);
                  state_d  = StResp;
               end else begin
                  // cnt_q counts beats still to send, including the current one
                  cnt_d   = cnt_q - 9'd1;
                  wlast_d = (cnt_q == 9'd2);
               end
            end
         end
         StResp: begin
            if (M_AXI_BVALID) begin
               bready_d = 1'b0;
               if (M_AXI_BRESP != 2'b00) begin
                  err_d = 1'b1;
               end
               // A bus error is recorded but the remaining bursts still run.
               if (rem_q != '0) begin
                  load_aw = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (load_aw) begin
         state_d   = StAddr;
         awvalid_d = 1'b1;
         awaddr_d  = calc_addr;
         awlen_d   = 8'(nb - 9'd1);
         beats_d   = nb;
      end
   end

   always_ff @(posedge ACLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         rem_q     <= '0;
         beats_q   <= '0;
         cnt_q     <= '0;
         awvalid_q <= 1'b0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         wlast_q   <= 1'b0;
         bready_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         beats_q   <= beats_d;
         cnt_q     <= cnt_d;
         awvalid_q <= awvalid_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         wlast_q   <= wlast_d;
         bready_q  <= bready_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign READY = (state_q == StIdle);
   assign DONE  = done_q;
   assign ERR   = err_q;

   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWLEN   = awlen_q;
   assign M_AXI_AWSIZE  = 3'(SZ);
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWCACHE = 4'b0011;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;

   // W channel follows the FWFT FIFO combinationally.
   assign M_AXI_WVALID = (state_q == StData) & ~FIFO_EMPTY;
   assign M_AXI_WDATA  = FIFO_DATA;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_WLAST  = wlast_q;
   assign FIFO_RE      = w_hs;

   assign M_AXI_BREADY = bready_q;

endmodule

// File: tb/tb_aq_axi_sdma_wr_engine.sv
// tb_aq_axi_sdma_wr_engine
//
// Self-checking bench for aq_axi_sdma_wr_engine (DATA_W=64, MAX_BURST=16).
// An AXI slave / FIFO model drives the DUT; expected AW and W traffic plus the
// expected ERR value at DONE are pushed to queues when a transfer is started
// and popped as the DUT produces handshakes. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_aq_axi_sdma_wr_engine;

   logic        ACLK = 1'b0;
   logic        RST  = 1'b1;
   logic        START = 1'b0;
   logic [31:0] ADRS = '0;
   logic [31:0] LEN  = '0;
`ifdef AQ_SDMA_FRAME_SYNC_EN
   logic        FRAME_SYNC = 1'b1;
`else
   logic        FRAME_SYNC = 1'b0;
`endif
   logic        READY, DONE, ERR, FIFO_RE;
   logic        FIFO_EMPTY = 1'b0;
   logic [63:0] FIFO_DATA = '0;
   logic [31:0] M_AXI_AWADDR;
   logic [7:0]  M_AXI_AWLEN;
   logic [2:0]  M_AXI_AWSIZE;
   logic [1:0]  M_AXI_AWBURST;
   logic [3:0]  M_AXI_AWCACHE;
   logic [2:0]  M_AXI_AWPROT;
   logic        M_AXI_AWVALID;
   logic        M_AXI_AWREADY = 1'b0;
   logic [63:0] M_AXI_WDATA;
   logic [7:0]  M_AXI_WSTRB;
   logic        M_AXI_WLAST, M_AXI_WVALID;
   logic        M_AXI_WREADY = 1'b0;
   logic [1:0]  M_AXI_BRESP = 2'b00;
   logic        M_AXI_BVALID = 1'b0;
   logic        M_AXI_BREADY;

   aq_axi_sdma_wr_engine #(
      .DATA_W(64), .ADDR_W(32), .LEN_W(32), .MAX_BURST(16)
   ) dut (
      .ACLK(ACLK), .RST(RST), .START(START), .ADRS(ADRS), .LEN(LEN),
      .FRAME_SYNC(FRAME_SYNC), .READY(READY), .DONE(DONE), .ERR(ERR),
      .FIFO_RE(FIFO_RE), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
      .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
      .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
   typedef struct { logic [63:0] data; logic last; } w_t;

   aw_t  aw_q[$];
   w_t   w_q[$];
   logic done_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned fifo_head = 0;
   int unsigned exp_seq   = 0;
   int          err_burst = -1;
   int          burst_idx = 0;
   int          fifo_mode = 2;   // 0 random empty, 1 toggle every 3 cycles, 2 never empty
   int          wready_mode = 0; // 0 random, 1 always ready
   int unsigned cyc = 0;
   int          done_cnt = 0;
   int          w_beats  = 0;
   logic        in_data  = 1'b0;
   logic        hs_pop = 1'b0, hs_b = 1'b0, hs_wlast = 1'b0;
   logic        b_pend = 1'b0;
   int          b_delay = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] word(input int unsigned n);
      return {n ^ 32'h5A5A_A5A5, n};
   endfunction

   // AXI slave and FIFO model
   always @(posedge ACLK) begin
      #1;
      cyc++;
      if (RST) begin
         M_AXI_BVALID = 1'b0;
         b_pend = 1'b0;
      end else begin
         if (hs_pop) fifo_head++;
         if (hs_b) begin
            M_AXI_BVALID = 1'b0;
            burst_idx++;
         end
         if (hs_wlast) begin
            b_pend  = 1'b1;
            b_delay = $urandom_range(0, 2);
         end
         if (b_pend) begin
            if (b_delay == 0) begin
               M_AXI_BVALID = 1'b1;
               M_AXI_BRESP  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
               b_pend = 1'b0;
            end else begin
               b_delay--;
            end
         end
      end
      M_AXI_AWREADY = ($urandom_range(0, 1) == 1);
      M_AXI_WREADY  = (wready_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      case (fifo_mode)
         0:       FIFO_EMPTY = ($urandom_range(0, 3) == 0);
         1:       FIFO_EMPTY = (((cyc / 3) % 2) == 1);
         default: FIFO_EMPTY = 1'b0;
      endcase
      FIFO_DATA = word(fifo_head);
   end

   // Monitor / scoreboard
   always @(negedge ACLK) begin
      logic hs_aw, hs_w;
      hs_wlast = 1'b0;
      if (RST) begin
         hs_pop = 1'b0;
         hs_b   = 1'b0;
      end else begin
         hs_aw = M_AXI_AWVALID & M_AXI_AWREADY;
         hs_w  = M_AXI_WVALID & M_AXI_WREADY;
         hs_b  = M_AXI_BVALID & M_AXI_BREADY;
         hs_pop = FIFO_RE;
         check_eq("wvalid", M_AXI_WVALID, in_data & ~FIFO_EMPTY);
         check_eq("fifo_re", FIFO_RE, in_data & ~FIFO_EMPTY & M_AXI_WREADY);
         if (hs_aw) begin
            check_eq("aw_size", M_AXI_AWSIZE, 3'd3);
            check_eq("aw_burst", M_AXI_AWBURST, 2'b01);
            if (aw_q.size() == 0) begin
               check_eq("aw_unexpected", 1, 0);
            end else begin
               aw_t e;
               e = aw_q.pop_front();
               check_eq("aw_addr", M_AXI_AWADDR, e.addr);
               check_eq("aw_len", M_AXI_AWLEN, e.len);
            end
         end
         if (hs_w) begin
            w_beats++;
            if (w_q.size() == 0) begin
               check_eq("w_unexpected", 1, 0);
            end else begin
               w_t e;
               e = w_q.pop_front();
               check_eq("w_data", M_AXI_WDATA, e.data);
               check_eq("w_last", M_AXI_WLAST, e.last);
               check_eq("w_strb", M_AXI_WSTRB, 8'hFF);
               if (e.last) begin
                  in_data  = 1'b0;
                  hs_wlast = 1'b1;
               end
            end
         end
         if (DONE) begin
            done_cnt++;
            check_eq("ready_at_done", READY, 1);
            check_eq("aw_left_at_done", aw_q.size(), 0);
            check_eq("w_left_at_done", w_q.size(), 0);
            if (done_q.size() == 0) check_eq("done_unexpected", 1, 0);
            else check_eq("err_at_done", ERR, done_q.pop_front());
         end
         if (hs_aw) in_data = 1'b1;
      end
   end

   // Reference burst split: min(remaining, 16, beats to 4 KB page end).
   task automatic push_expect(input logic [31:0] adrs, input logic [31:0] len, input int errb);
      logic [31:0] a, rem;
      int nbursts, b, page;
      a = adrs & 32'hFFFF_FFF8;
      rem = len;
      nbursts = 0;
      while (rem != 0) begin
         page = (4096 - int'(a[11:0])) / 8;
         b = (rem < 16) ? int'(rem) : 16;
         if (page < b) b = page;
         aw_q.push_back('{addr: a, len: 8'(b - 1)});
         for (int i = 0; i < b; i++) begin
            w_q.push_back('{data: word(exp_seq), last: (i == b - 1)});
            exp_seq++;
         end
         a   = a + 32'(b * 8);
         rem = rem - 32'(b);
         nbursts++;
      end
      done_q.push_back(errb >= 0 && errb < nbursts);
   endtask

   task automatic start_xfer(input logic [31:0] adrs, input logic [31:0] len, input int errb);
      int i = 0;
      @(posedge ACLK); #1;
      while (!READY && i < 3000) begin
         @(posedge ACLK); #1;
         i++;
      end
      if (!READY) check_eq("ready_timeout", 0, 1);
      err_burst = errb;
      burst_idx = 0;
      push_expect(adrs, len, errb);
      START = 1'b1;
      ADRS  = adrs;
      LEN   = len;
      @(posedge ACLK); #1;
      START = 1'b0;
      @(negedge ACLK);
      check_eq("err_cleared", ERR, 0);
      if (len != 0) begin
         check_eq("ready_busy", READY, 0);
`ifndef AQ_SDMA_FRAME_SYNC_EN
         check_eq("aw_at_n1", M_AXI_AWVALID, 1);
`endif
      end
   endtask

   task automatic wait_done(input int target);
      int i = 0;
      while (done_cnt < target && i < 3000) begin
         @(negedge ACLK);
         i++;
      end
      if (done_cnt < target) check_eq("done_timeout", 0, 1);
   endtask

   initial begin
      int pops0, t;
      repeat (3) @(negedge ACLK);
      check_eq("rst_ready", READY, 1);
      check_eq("rst_awvalid", M_AXI_AWVALID, 0);
      check_eq("rst_wvalid", M_AXI_WVALID, 0);
      check_eq("rst_fifo_re", FIFO_RE, 0);
      check_eq("rst_bready", M_AXI_BREADY, 0);
      check_eq("rst_done", DONE, 0);
      check_eq("rst_err", ERR, 0);
      @(posedge ACLK); #1;
      RST = 1'b0;

      // 40 beats from 0x1000: 16 + 16 + 8
      fifo_mode = 0;
      pops0 = int'(fifo_head);
      t = done_cnt;
      start_xfer(32'h1000, 40, -1);
      wait_done(t + 1);
      @(posedge ACLK); #2;
      check_eq("pops_40", fifo_head - pops0, 40);
      check_eq("err_40", ERR, 0);

      // 4 beats from 0x0FF0: 2 + 2 split at the page boundary
      t = done_cnt;
      start_xfer(32'h0FF0, 4, -1);
      wait_done(t + 1);

      // Zero length: DONE one cycle after acceptance, READY never drops
      t = done_cnt;
      start_xfer(32'h3000, 0, -1);
      check_eq("len0_done", DONE, 1);
      check_eq("len0_ready", READY, 1);
      check_eq("len0_awvalid", M_AXI_AWVALID, 0);
      @(negedge ACLK);
      check_eq("len0_done_pulse", DONE, 0);
      check_eq("len0_ready2", READY, 1);
      check_eq("len0_done_cnt", done_cnt, t + 1);

      // Error on burst 2 of 3; all bursts still complete
      t = done_cnt;
      start_xfer(32'h6000, 48, 1);
      wait_done(t + 1);
      @(negedge ACLK);
      check_eq("err_sticky", ERR, 1);

      // FIFO empty toggling every 3 cycles during a 16-beat burst (clears ERR)
      fifo_mode = 1;
      wready_mode = 1;
      t = done_cnt;
      start_xfer(32'h7000, 16, -1);
      wait_done(t + 1);
      fifo_mode = 0;
      wready_mode = 0;

      // Address wrap at the top of the address space: 4 + 6 beats
      t = done_cnt;
      start_xfer(32'hFFFF_FFE0, 10, -1);
      wait_done(t + 1);

`ifdef AQ_SDMA_FRAME_SYNC_EN
      FRAME_SYNC = 1'b0;
      t = done_cnt;
      start_xfer(32'h8000, 8, -1);
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         check_eq("sync_wait_aw", M_AXI_AWVALID, 0);
      end
      @(posedge ACLK); #1;
      FRAME_SYNC = 1'b1;
      @(negedge ACLK);
      check_eq("sync_aw_before", M_AXI_AWVALID, 0);
      @(negedge ACLK);
      check_eq("sync_aw_after", M_AXI_AWVALID, 1);
      wait_done(t + 1);
`endif

      // Reset in the middle of a data phase
      fifo_mode = 2;
      start_xfer(32'h2000, 32, -1);
      t = 0;
      pops0 = w_beats;
      while (w_beats < pops0 + 3 && t < 500) begin
         @(negedge ACLK);
         t++;
      end
      check_eq("mid_data_reached", in_data, 1);
      @(posedge ACLK); #1;
      RST = 1'b1;
      @(negedge ACLK);
      check_eq("mrst_ready", READY, 1);
      check_eq("mrst_awvalid", M_AXI_AWVALID, 0);
      check_eq("mrst_wvalid", M_AXI_WVALID, 0);
      check_eq("mrst_wlast", M_AXI_WLAST, 0);
      check_eq("mrst_fifo_re", FIFO_RE, 0);
      check_eq("mrst_bready", M_AXI_BREADY, 0);
      check_eq("mrst_done", DONE, 0);
      aw_q.delete();
      w_q.delete();
      done_q.delete();
      in_data = 1'b0;
      @(posedge ACLK); #1;
      RST = 1'b0;
      exp_seq = fifo_head;
      fifo_mode = 0;
      t = done_cnt;
      start_xfer(32'h2400, 8, -1);
      wait_done(t + 1);
      check_eq("final_err", ERR, 0);

      repeat (3) @(negedge ACLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aq_axi_sdma_wr_engine.md
# aq_axi_sdma_wr_engine

Parametrised stream-to-memory DMA write engine: the next generation of the fixed 64-bit SDMA write path. It drains a first-word-fall-through FIFO into memory through an AXI4 master write channel (AW/W/B). Transfers are split into INCR bursts that never exceed a configurable maximum length and never cross a 4 KB boundary. It sits between the write-side CDC FIFO and the AXI interconnect, and reports completion and bus errors to the control register block.

## Interface
- DATA_W, 64: AXI and FIFO data width; one of 32/64/128/256.
- ADDR_W, 32: AXI address width.
- LEN_W, 32: width of the beat-count input.
- MAX_BURST, 16: maximum beats per burst; power of 2, 1..256.

Ports (clock and reset first):
- ACLK  in  1  clock; all logic is on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  single-cycle request; accepted only when READY=1.
- ADRS  in  ADDR_W  start byte address, sampled with START.
- LEN  in  LEN_W  transfer length in beats, sampled with START.
- FRAME_SYNC  in  1  frame-sync qualifier (see Configuration).
- READY  out  1  engine idle.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky bus-error flag.
- FIFO_RE  out  1  FIFO pop.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_DATA  in  DATA_W  FIFO head word (FWFT).
- M_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWCACHE/AWPROT/AWVALID  out, M_AXI_AWREADY  in  standard AXI4.
- M_AXI_WDATA  out  DATA_W.
- M_AXI_WSTRB  out  DATA_W/8.
- M_AXI_WLAST/WVALID  out.
- M_AXI_WREADY  in.
- M_AXI_BRESP[1:0]/BVALID  in.
- M_AXI_BREADY  out.

## Operation
- Beat size B = DATA_W/8 bytes. AWSIZE = log2(B). AWBURST = 2'b01. AWCACHE = 4'b0011. AWPROT = 3'b000. WSTRB = all ones.
- ADRS low log2(B) bits are forced to 0.
- States: IDLE -> (SYNC) -> ADDR -> DATA -> RESP -> ADDR or IDLE.
- **IDLE:** READY=1. On START:
  - Latch the address and remaining count (rem=LEN). Clear ERR.
  - If LEN=0: pulse DONE next cycle and stay in IDLE; no AXI traffic.
  - Otherwise go to SYNC (macro defined) or ADDR.
- **Burst size:** beats = min(rem, MAX_BURST, (4096 - addr[11:0])/B). AWLEN = beats-1.
- **ADDR:** AWVALID=1, held with AWADDR/AWLEN stable until AWREADY. Then go to DATA.
- **DATA:**
  - WVALID = ~FIFO_EMPTY. FIFO_RE = WVALID & WREADY. WDATA = FIFO_DATA.
  - WLAST is high on the final beat of the burst.
  - An empty FIFO stalls the burst; no beat is dropped or duplicated.
  - Last beat accepted -> RESP. Update addr += beats*B and rem -= beats.
- **RESP:** BREADY=1. On BVALID:
  - BRESP != 2'b00 sets ERR.
  - If rem != 0, go to ADDR; otherwise pulse DONE and go to IDLE.
  - An error does not abort the remaining bursts.
- Only one burst is outstanding at a time. START while not READY is ignored.
- ERR holds until the next accepted START or RST.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- RST asserted: all outputs 0 except READY=1. State returns to IDLE and counters clear. This applies mid-burst as well; the interconnect must be reset alongside.
- START accepted at edge N -> AWVALID high from cycle N+1 (macro undefined).
- AW handshake at edge M -> WVALID may be high from cycle M+1.
- Final W handshake at edge K -> BREADY high from cycle K+1.
- B handshake at edge J:
  - next AWVALID at J+1, or
  - DONE high during cycle J+1, with READY high in the same cycle.
- A new START is accepted in the DONE cycle.
- Gap between bursts is ≥2 cycles (AW idle during RESP).
- All AXI outputs are registered except WVALID/WDATA/FIFO_RE, which follow FIFO_EMPTY/FIFO_DATA combinationally.

## Configuration
- Macro: AQ_SDMA_FRAME_SYNC_EN.
- **Defined:** after START the engine enters SYNC and waits for FRAME_SYNC=1 sampled at a clock edge. AWVALID asserts the following cycle. FRAME_SYNC is ignored outside SYNC.
- **Undefined:** the SYNC state is omitted, the FRAME_SYNC input is unused, and START goes directly to ADDR.

## Test plan
- DATA_W=64, MAX_BURST=16, ADRS=0x1000, LEN=40 -> AW 0x1000/AWLEN 15, 0x1080/15, 0x1100/7. Exactly 40 FIFO pops, one DONE pulse, ERR=0.
- ADRS=0x0FF0, LEN=4 -> AW 0x0FF0/AWLEN 1, then 0x1000/AWLEN 1. No burst crosses 0x1000.
- LEN=0 -> no AWVALID. DONE high exactly one cycle after START. READY never drops.
- LEN=48, BRESP=2'b10 on burst 2 of 3 -> all 3 bursts complete and ERR=1 at DONE. Next START clears ERR to 0.
- FIFO_EMPTY toggling every 3 cycles during a 16-beat burst -> WVALID follows ~FIFO_EMPTY. 16 beats with WDATA in order, WLAST only on beat 16.
- Macro defined, FRAME_SYNC low for 10 cycles after START -> AWVALID rises one cycle after FRAME_SYNC is sampled high.
- RST pulsed mid-DATA -> READY=1 and all other outputs 0 during reset. A following START with LEN=8 completes normally.
